// File: rtl/phase_timer_if.sv
// phase_timer_if: controller <-> phase timer bus
//   state       controller state (IDLE=00, RED=01, GREEN=10, YELLOW=11)
//   timer_value remaining ticks of the current phase
//   timer_done  one-cycle pulse when the phase expires
//   tick        one-cycle pulse per countdown step
//   blink       phase-aligned square wave, 0 in IDLE
interface phase_timer_if;
  logic [1:0] state;
  logic [3:0] timer_value;
  logic       timer_done;
  logic       tick;
  logic       blink;
  modport master (output state, input timer_value, timer_done, tick, blink);
  modport slave (input state, output timer_value, timer_done, tick, blink);
endinterface

// File: rtl/phase_timer.sv
// phase_timer: per-phase countdown, done pulse and blink for the traffic-light controller
//   clk   system clock
//   reset synchronous, active-high
//   tmr   slave side of phase_timer_if (state in; timer_value, timer_done, tick, blink out)
module phase_timer #(
  parameter int TICK_DIV   = 125000000,
  parameter int BLINK_DIV  = 31250000,
  parameter int RED_SEC    = 9,
  parameter int GREEN_SEC  = 9,
  parameter int YELLOW_SEC = 3
) (
  input logic           clk,
  input logic           reset,
  phase_timer_if.slave  tmr
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  // a zero duration would never produce timer_done, so it is promoted to one tick
  localparam logic [3:0] RED_D    = RED_SEC == 0 ? 4'd1 : 4'(RED_SEC);
  localparam logic [3:0] GREEN_D  = GREEN_SEC == 0 ? 4'd1 : 4'(GREEN_SEC);
  localparam logic [3:0] YELLOW_D = YELLOW_SEC == 0 ? 4'd1 : 4'(YELLOW_SEC);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);
  logic [1:0]    state_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [3:0]    tv_q, tv_d, dur;
  logic          done_q, done_d, tick_q, tick_d, blink_q, blink_d;
  logic          idle, chg, pwrap, bwrap;
  assign idle  = tmr.state == 2'd0;
  assign chg   = tmr.state != state_q;
  assign pwrap = presc_q == P_LAST;
  assign bwrap = bcnt_q == B_LAST;
  assign dur   = tmr.state == 2'd1 ? RED_D : tmr.state == 2'd2 ? GREEN_D : YELLOW_D;
  // idle clears everything; a state change reloads and swallows any coincident tick
  always_comb begin
    tv_d    = 4'd0;
    presc_d = '0;
    bcnt_d  = '0;
    done_d  = 1'b0;
    tick_d  = 1'b0;
    blink_d = 1'b0;
    if (!idle && chg) begin
      tv_d = dur;
    end else if (!idle) begin
      presc_d = pwrap ? '0 : presc_q + 1'b1;
      tick_d  = pwrap;
      tv_d    = !pwrap ? tv_q : tv_q > 4'd1 ? tv_q - 4'd1 : 4'd0;
      done_d  = pwrap && tv_q == 4'd1;
      bcnt_d  = bwrap ? '0 : bcnt_q + 1'b1;
      blink_d = bwrap ? !blink_q : blink_q;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= 2'd0;
      presc_q <= '0;
      bcnt_q  <= '0;
      tv_q    <= 4'd0;
      done_q  <= 1'b0;
      tick_q  <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      state_q <= tmr.state;
      presc_q <= presc_d;
      bcnt_q  <= bcnt_d;
      tv_q    <= tv_d;
      done_q  <= done_d;
      tick_q  <= tick_d;
      blink_q <= blink_d;
    end
  end
  assign tmr.timer_value = tv_q;
  assign tmr.timer_done  = done_q;
  assign tmr.tick        = tick_q;
  assign tmr.blink       = blink_q;
endmodule

// File: tb/tb_phase_timer.sv
// tb_phase_timer: directed checks of phase_timer with TICK_DIV=4, BLINK_DIV=2
module tb_phase_timer;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  phase_timer_if bus ();
  phase_timer #(.TICK_DIV(4), .BLINK_DIV(2), .RED_SEC(9), .GREEN_SEC(9), .YELLOW_SEC(3))
    dut (.clk(clk), .reset(reset), .tmr(bus.slave));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask
  initial begin
    int ticks;
    int nloads;
    int dones;
    int zeros;
    int budget;
    logic pending;
    logic [3:0] prev_tv;
    logic [1:0] nxt;
    int exp_load [4] = '{9, 9, 3, 9};
    @(negedge clk);
    reset = 1'b1;
    bus.state = 2'd1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_tv", bus.timer_value, 0);
      chk("rst_done", bus.timer_done, 0);
      chk("rst_tick", bus.tick, 0);
      chk("rst_blink", bus.blink, 0);
    end
    reset = 1'b0;
    step();
    chk("post_rst_load", bus.timer_value, 9);
    bus.state = 2'd0;
    step();
    chk("idle_tv", bus.timer_value, 0);
    bus.state = 2'd1;
    ticks = 0;
    for (int c = 1; c <= 41; c++) begin
      step();
      chk("cd_tv", bus.timer_value, c <= 36 ? 9 - (c - 1) / 4 : 0);
      chk("cd_done", bus.timer_done, c == 37);
      chk("cd_tick", bus.tick, c >= 5 && (c - 1) % 4 == 0);
      if (c <= 38 && bus.tick) ticks++;
    end
    chk("cd_tick_count", ticks, 9);
    bus.state = 2'd0;
    step();
    bus.state = 2'd1;
    for (int c = 1; c <= 17; c++) step();
    chk("abort_tv5", bus.timer_value, 5);
    bus.state = 2'd0;
    step();
    chk("abort_tv0", bus.timer_value, 0);
    for (int c = 0; c < 6; c++) begin
      chk("abort_done", bus.timer_done, 0);
      chk("abort_tick", bus.tick, 0);
      chk("abort_blink", bus.blink, 0);
      step();
    end
    bus.state = 2'd2;
    for (int c = 1; c <= 36; c++) step();
    chk("col_tv1", bus.timer_value, 1);
    bus.state = 2'd3;
    step();
    chk("col_tv", bus.timer_value, 3);
    chk("col_done", bus.timer_done, 0);
    chk("col_tick", bus.tick, 0);
    chk("col_blink", bus.blink, 0);
    step();
    chk("col_tick2", bus.tick, 0);
    chk("col_tv2", bus.timer_value, 3);
    bus.state = 2'd0;
    step();
    bus.state = 2'd2;
    for (int c = 1; c <= 8; c++) begin
      step();
      chk("blink_pat", bus.blink, ((c - 1) >> 1) & 1);
    end
    bus.state = 2'd1;
    step();
    chk("blink_chg", bus.blink, 0);
    chk("blink_chg_tv", bus.timer_value, 9);
    bus.state = 2'd0;
    step();
    bus.state = 2'd1;
    pending = 1'b0;
    nloads = 0;
    dones = 0;
    zeros = 0;
    prev_tv = 4'd0;
    budget = 400;
    while (nloads < 4 && budget > 0) begin
      step();
      budget--;
      if (pending) begin
        nxt = bus.state == 2'd3 ? 2'd1 : bus.state + 2'd1;
        bus.state = nxt;
        pending = 1'b0;
      end
      if (bus.timer_done) pending = 1'b1;
      if (bus.timer_value != 0 && prev_tv == 0) begin
        if (nloads > 0) begin
          chk("loop_dones", dones, 1);
          chk("loop_gap", zeros, 2);
        end
        chk("loop_load", bus.timer_value, exp_load[nloads]);
        nloads++;
        dones = 0;
        zeros = 0;
      end
      if (bus.timer_value == 0) zeros++;
      if (bus.timer_done) dones++;
      prev_tv = bus.timer_value;
    end
    chk("loop_phases", nloads, 4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
